mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: load/store unit between the Execute stage and a simple
// request/grant data bus. Accepts one memory op at a time, drives a single
// word-aligned bus request with byte strobes, waits for grant (and read data
// for loads), extends the loaded value and reports completion or error.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ex_valid          Execute presents a valid instruction
//   MemRead/MemWrite  load / store
//   Funct3            access width and signedness
//   ALUresult         effective byte address
//   Reg2RD            store data
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb   registered bus request
//   bus_gnt, bus_rvalid, bus_rdata                bus response
//   stall             freeze upstream (combinational in the accept cycle)
//   mem_done/mem_err  one-cycle completion pulse and its error qualifier
//   mem_rdata         extended load result, held until the next good load
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUresult,
  input  logic [31:0] Reg2RD,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        mem_done,
  output logic        mem_err,
  output logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         addr_lo_q;
  logic [2:0]         funct3_q;
  logic               is_load_q;

  logic               bus_req_d;
  logic               mem_done_d;
  logic               mem_err_d;
  logic [31:0]        mem_rdata_d;
  logic               capture_c;

  logic               accept_c;
  logic               op_err_c;
  logic               tmo_hit_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [3:0]         wstrb_c;
  logic [31:0]        wdata_c;
  logic [31:0]        load_ext_c;
  logic [7:0]         ld_byte_c;
  logic [15:0]        ld_half_c;

  assign accept_c  = (state_q == IDLE) && ex_valid && (MemRead || MemWrite);
  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign tmo_hit_c = (cnt_inc_c >= CNT_W'(TIMEOUT_CYCLES));
  assign stall     = accept_c || (state_q == REQ) || (state_q == WAIT);

  // Illegal opcode combination, unsupported width or misalignment.
  always_comb begin
    op_err_c = 1'b0;
    if (MemRead && MemWrite) begin
      op_err_c = 1'b1;
    end else if (MemRead) begin
      case (Funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_err_c = 1'b0;
        default:                                op_err_c = 1'b1;
      endcase
    end else begin
      op_err_c = Funct3[2] || (Funct3[1:0] == 2'b11);
    end
    if ((Funct3[1:0] == 2'b01) && ALUresult[0])
      op_err_c = 1'b1;
    if ((Funct3[1:0] == 2'b10) && (ALUresult[1:0] != 2'b00))
      op_err_c = 1'b1;
  end

  // Store lane replication and byte enables; loads drive no strobes.
  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = 32'h0;
    if (MemWrite) begin
      case (Funct3[1:0])
        2'b00: begin
          wstrb_c = 4'b0001 << ALUresult[1:0];
          wdata_c = {4{Reg2RD[7:0]}};
        end
        2'b01: begin
          wstrb_c = ALUresult[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{Reg2RD[15:0]}};
        end
        default: begin
          wstrb_c = 4'b1111;
          wdata_c = Reg2RD;
        end
      endcase
    end
  end

  // Select and extend the addressed byte/halfword of the returned word.
  always_comb begin
    case (addr_lo_q)
      2'b00:   ld_byte_c = bus_rdata[7:0];
      2'b01:   ld_byte_c = bus_rdata[15:8];
      2'b10:   ld_byte_c = bus_rdata[23:16];
      default: ld_byte_c = bus_rdata[31:24];
    endcase
    ld_half_c = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b100:  load_ext_c = {24'h0, ld_byte_c};
      3'b001:  load_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b101:  load_ext_c = {16'h0, ld_half_c};
      default: load_ext_c = bus_rdata;
    endcase
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req;
    mem_done_d  = 1'b0;
    mem_err_d   = 1'b0;
    mem_rdata_d = mem_rdata;
    capture_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          cnt_d = '0;
          if (op_err_c) begin
            state_d    = DONE;
            mem_done_d = 1'b1;
            mem_err_d  = 1'b1;
          end else begin
            state_d   = REQ;
            bus_req_d = 1'b1;
            capture_c = 1'b1;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc_c;
        // A load granted on its last budgeted cycle has no time left for data.
        if (bus_gnt && !(is_load_q && tmo_hit_c)) begin
          bus_req_d = 1'b0;
          if (is_load_q) begin
            state_d = WAIT;
          end else begin
            state_d    = DONE;
            mem_done_d = 1'b1;
          end
        end else if (tmo_hit_c) begin
          bus_req_d  = 1'b0;
          state_d    = DONE;
          mem_done_d = 1'b1;
          mem_err_d  = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc_c;
        if (bus_rvalid) begin
          state_d     = DONE;
          mem_done_d  = 1'b1;
          mem_rdata_d = load_ext_c;
        end else if (tmo_hit_c) begin
          state_d    = DONE;
          mem_done_d = 1'b1;
          mem_err_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_lo_q <= 2'b00;
      funct3_q  <= 3'b000;
      is_load_q <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_wstrb <= 4'b0000;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_req   <= bus_req_d;
      mem_done  <= mem_done_d;
      mem_err   <= mem_err_d;
      mem_rdata <= mem_rdata_d;
      if (capture_c) begin
        addr_lo_q <= ALUresult[1:0];
        funct3_q  <= Funct3;
        is_load_q <= MemRead;
        bus_we    <= MemWrite;
        bus_addr  <= {ALUresult[31:2], 2'b00};
        bus_wdata <= wdata_c;
        bus_wstrb <= wstrb_c;
      end
    end
  end

endmodule
